// File: rtl/mdio_pkg.sv
// MDIO generator shared types: state encoding, opcodes, frame layout.
// MDIO_PREAMBLE_EN adds the 32-bit all-ones preamble state.
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef MDIO_PREAMBLE_EN
    S_PREAMBLE,
`endif
    S_SEND,
    S_READ,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam int FRAME_LEN = 32;
  localparam int ST_MSB    = 31;
  localparam int ST_LSB    = 30;
  localparam int OP_MSB    = 29;
  localparam int OP_LSB    = 28;
  localparam int PHY_MSB   = 27;
  localparam int PHY_LSB   = 23;
  localparam int REG_MSB   = 22;
  localparam int REG_LSB   = 18;
  localparam int TA_MSB    = 17;
  localparam int TA_LSB    = 16;
  localparam int DATA_MSB  = 15;
  localparam int DATA_LSB  = 0;

  // bit_cnt landmarks: last frame bit, last driven bit of a read, read end
  localparam logic [5:0] LAST_BIT = 6'(FRAME_LEN - 1);
  localparam logic [5:0] RD_LAST  = 6'(FRAME_LEN - TA_LSB - 1);
  localparam logic [5:0] END_CNT  = 6'(FRAME_LEN);

endpackage

// File: rtl/mdio_clk_div.sv
// MDC generator: toggles every CLK_DIV clks while enabled, low otherwise.
// mdc_rise/mdc_fall flag the clk on which MDC is about to change.
module mdio_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic mdc,
  output logic mdc_rise,
  output logic mdc_fall
);

  logic [7:0] cnt;
  logic       tick;

  assign tick     = en && (cnt == 8'(CLK_DIV - 1));
  assign mdc_rise = tick && !mdc;
  assign mdc_fall = tick && mdc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mdio_generator.sv
// MDIO management frame generator with read-data capture.
// Define MDIO_PREAMBLE_EN to prepend 32 MDC periods of ones.
module mdio_generator
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY
);

  state_t      state, state_nxt;
  logic [31:0] frame, frame_nxt;
  logic [5:0]  bit_cnt, bit_cnt_nxt;
  logic [14:0] rd_sh, rd_sh_nxt;
  logic [15:0] rd_data_nxt;
  logic        rdy_nxt, busy_nxt;
  logic        out_nxt, oe_nxt, pre_nxt;
  logic        en, mdc_rise, mdc_fall;

  assign en = (state != S_IDLE) && (state != S_DONE);

  mdio_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mdc      (MDC),
    .mdc_rise (mdc_rise),
    .mdc_fall (mdc_fall)
  );

  always_comb begin
    state_nxt   = state;
    frame_nxt   = frame;
    bit_cnt_nxt = bit_cnt;
    rd_sh_nxt   = rd_sh;
    rd_data_nxt = RD_DATA;
    rdy_nxt     = 1'b0;
    busy_nxt    = BUSY;
    unique case (state)
      S_IDLE: begin
        if (MDIO_START) begin
          frame_nxt   = T_DATA;
          bit_cnt_nxt = '0;
          busy_nxt    = 1'b1;
`ifdef MDIO_PREAMBLE_EN
          state_nxt   = S_PREAMBLE;
`else
          state_nxt   = S_SEND;
`endif
        end
      end
`ifdef MDIO_PREAMBLE_EN
      S_PREAMBLE: begin
        if (mdc_fall) begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nxt = '0;
            state_nxt   = S_SEND;
          end else begin
            bit_cnt_nxt = bit_cnt + 6'd1;
          end
        end
      end
`endif
      S_SEND: begin
        if (mdc_fall) begin
          if (bit_cnt == LAST_BIT) begin
            state_nxt = S_DONE;
          end else begin
            bit_cnt_nxt = bit_cnt + 6'd1;
            if (frame[OP_MSB:OP_LSB] == OP_READ && bit_cnt == RD_LAST)
              state_nxt = S_READ;
          end
        end
      end
      S_READ: begin
        // bit_cnt runs 16..32 here; 32 marks the final half-period
        if (mdc_rise) begin
          rd_sh_nxt   = {rd_sh[13:0], MDIO_IN};
          bit_cnt_nxt = bit_cnt + 6'd1;
          if (bit_cnt == LAST_BIT) begin
            rd_data_nxt = {rd_sh, MDIO_IN};
            rdy_nxt     = 1'b1;
          end
        end else if (mdc_fall && bit_cnt == END_CNT) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

`ifdef MDIO_PREAMBLE_EN
    pre_nxt = (state_nxt == S_PREAMBLE);
`else
    pre_nxt = 1'b0;
`endif
    // outputs are registered from next state so they move with MDC falls
    oe_nxt  = (state_nxt == S_SEND) || pre_nxt;
    out_nxt = (state_nxt == S_SEND) ? frame_nxt[~bit_cnt_nxt[4:0]]
                                    : pre_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      frame    <= '0;
      bit_cnt  <= '0;
      rd_sh    <= '0;
      RD_DATA  <= '0;
      DATA_RDY <= 1'b0;
      BUSY     <= 1'b0;
      MDIO_OUT <= 1'b0;
      MDIO_OE  <= 1'b0;
    end else begin
      state    <= state_nxt;
      frame    <= frame_nxt;
      bit_cnt  <= bit_cnt_nxt;
      rd_sh    <= rd_sh_nxt;
      RD_DATA  <= rd_data_nxt;
      DATA_RDY <= rdy_nxt;
      BUSY     <= busy_nxt;
      MDIO_OUT <= out_nxt;
      MDIO_OE  <= oe_nxt;
    end
  end

endmodule

// File: tb/tb_mdio_generator.sv
// Directed bench for mdio_generator: write, read, ignored start, abort, OP=11.
// Honours MDIO_PREAMBLE_EN when the design is built with it.
module tb_mdio_generator;

  localparam int CLK_DIV = 2;
`ifdef MDIO_PREAMBLE_EN
  localparam int PRE = 32;
`else
  localparam int PRE = 0;
`endif
  localparam int NPER  = PRE + 32;
  localparam int NBUSY = NPER * 2 * CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MDIO_START = 1'b0;
  logic [31:0] T_DATA = '0;
  logic        MDIO_IN = 1'b0;
  logic        MDC, MDIO_OUT, MDIO_OE, DATA_RDY, BUSY;
  logic [15:0] RD_DATA;

  int          n_chk = 0;
  int          n_pass = 0;
  int          busy_n, rdy_n, rises;
  logic [63:0] obs_oe, obs_out;

  always #5 clk = ~clk;

  mdio_generator #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .MDIO_START (MDIO_START),
    .T_DATA     (T_DATA),
    .MDIO_IN    (MDIO_IN),
    .MDC        (MDC),
    .MDIO_OUT   (MDIO_OUT),
    .MDIO_OE    (MDIO_OE),
    .RD_DATA    (RD_DATA),
    .DATA_RDY   (DATA_RDY),
    .BUSY       (BUSY)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] exp_oe(input logic [31:0] fr);
    logic [63:0] v;
    v = '0;
    for (int p = 0; p < NPER; p++) begin
      if (p < PRE) v[p] = 1'b1;
      else if (!(fr[29:28] == 2'b10 && p - PRE >= 16)) v[p] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [63:0] exp_out(input logic [31:0] fr);
    logic [63:0] v;
    logic [63:0] oe;
    oe = exp_oe(fr);
    v = '0;
    for (int p = 0; p < NPER; p++) begin
      if (p < PRE) v[p] = 1'b1;
      else if (oe[p]) v[p] = fr[31 - (p - PRE)];
    end
    return v;
  endfunction

  // Launch one frame, watch it clk by clk and play the PHY's read data.
  task automatic run(input logic [31:0] fr, input logic [15:0] rdv,
                     input int inj_at, input logic [31:0] inj_fr,
                     input int abort_at);
    logic mq;
    int   k;
    busy_n = 0; rdy_n = 0; rises = 0;
    obs_oe = '0; obs_out = '0; mq = 1'b0;
    @(negedge clk);
    T_DATA = fr;
    MDIO_START = 1'b1;
    @(negedge clk);
    MDIO_START = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (BUSY) busy_n++;
      if (DATA_RDY) rdy_n++;
      if (MDC && !mq && rises < 64) begin
        obs_oe[rises] = MDIO_OE;
        obs_out[rises] = MDIO_OUT;
        rises++;
      end
      mq = MDC;
      if (abort_at >= 0 && rises == abort_at) begin
        reset = 1'b1;
        #1;
        check("abort_ctl", 64'({MDC, MDIO_OE, MDIO_OUT, BUSY, DATA_RDY}), 64'd0);
        check("abort_rd", 64'(RD_DATA), 64'd0);
        break;
      end
      if (!BUSY && busy_n > 0) break;
      k = rises - PRE - 16;
      MDIO_IN = (k >= 0 && k < 16) ? rdv[15 - k] : 1'b0;
      if (busy_n == inj_at) begin
        T_DATA = inj_fr;
        MDIO_START = 1'b1;
      end else begin
        MDIO_START = 1'b0;
      end
      @(negedge clk);
    end
    MDIO_START = 1'b0;
    MDIO_IN = 1'b0;
  endtask

  task automatic check_txn(input string tag, input logic [31:0] fr,
                           input int exp_rdy);
    check({tag, "_busy"}, 64'(busy_n), 64'(NBUSY));
    check({tag, "_periods"}, 64'(rises), 64'(NPER));
    check({tag, "_oe"}, obs_oe, exp_oe(fr));
    check({tag, "_bits"}, obs_out, exp_out(fr));
    check({tag, "_rdy"}, 64'(rdy_n), 64'(exp_rdy));
    check({tag, "_idle"}, 64'({MDC, MDIO_OE, MDIO_OUT, BUSY}), 64'd0);
  endtask

  logic [31:0] w1, r1, w2, inj, r2, o3;

  initial begin
    w1  = {2'b01, 2'b01, 5'h03, 5'h0A, 2'b10, 16'hBEEF};
    r1  = {2'b01, 2'b10, 5'h03, 5'h0A, 2'b11, 16'h0000};
    w2  = {2'b01, 2'b01, 5'h1F, 5'h01, 2'b10, 16'h1234};
    inj = {2'b01, 2'b10, 5'h07, 5'h07, 2'b10, 16'hFFFF};
    r2  = {2'b01, 2'b10, 5'h11, 5'h02, 2'b00, 16'h0000};
    o3  = {2'b01, 2'b11, 5'h02, 5'h1C, 2'b10, 16'h0F0F};

    repeat (3) @(negedge clk);
    check("rst_ctl", 64'({MDC, MDIO_OE, MDIO_OUT, BUSY, DATA_RDY}), 64'd0);
    check("rst_rd", 64'(RD_DATA), 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_ctl", 64'({MDC, MDIO_OE, MDIO_OUT, BUSY, DATA_RDY}), 64'd0);

    run(w1, 16'h0000, -1, '0, -1);
    check_txn("wr", w1, 0);
    check("wr_rd_hold", 64'(RD_DATA), 64'd0);

    run(r1, 16'hA5C3, -1, '0, -1);
    check_txn("rd", r1, 1);
    check("rd_data", 64'(RD_DATA), 64'hA5C3);

    run(w2, 16'h0000, 40, inj, -1);
    check_txn("inj", w2, 0);
    check("inj_rd_hold", 64'(RD_DATA), 64'hA5C3);
    repeat (4) @(negedge clk);
    check("inj_no_start", 64'(BUSY), 64'd0);

    run(r2, 16'hFFFF, -1, '0, PRE + 20);
    check("abort_no_rdy", 64'(rdy_n), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_idle", 64'({MDC, MDIO_OE, BUSY, DATA_RDY}), 64'd0);

    run(r2, 16'h3C5A, -1, '0, -1);
    check_txn("rd2", r2, 1);
    check("rd2_data", 64'(RD_DATA), 64'h3C5A);

    run(o3, 16'hFFFF, -1, '0, -1);
    check_txn("op11", o3, 0);
    check("op11_rd_hold", 64'(RD_DATA), 64'h3C5A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
